// File: rtl/if_stage_controller_if.sv
// Fetch-stage bundle: hazard/branch requests and instruction memory in,
// PC, IF/ID contents, ID/EX bubble request, counters and error flags out.
interface if_stage_controller_if #(
    parameter int CNT_W = 32
);
    logic              stall;
    logic              pc_write_zero;
    logic              IFID_pipeline_write_zero;
    logic              branch_taken_E;
    logic [31:0]       branch_target_E;
    logic              imem_valid;
    logic [31:0]       imem_rdata;
    logic [31:0]       imem_addr;
    logic [31:0]       pc_F;
    logic [31:0]       instr_D;
    logic [31:0]       pc_D;
    logic              valid_D;
    logic              idex_flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  imem_wait_cnt;
    logic              protocol_err;
    logic              misalign_err;

    modport master (
        output stall, pc_write_zero, IFID_pipeline_write_zero,
        output branch_taken_E, branch_target_E, imem_valid, imem_rdata,
        input  imem_addr, pc_F, instr_D, pc_D, valid_D, idex_flush,
        input  stall_cnt, flush_cnt, imem_wait_cnt, protocol_err, misalign_err
    );

    modport slave (
        input  stall, pc_write_zero, IFID_pipeline_write_zero,
        input  branch_taken_E, branch_target_E, imem_valid, imem_rdata,
        output imem_addr, pc_F, instr_D, pc_D, valid_D, idex_flush,
        output stall_cnt, flush_cnt, imem_wait_cnt, protocol_err, misalign_err
    );
endinterface

// File: rtl/if_stage_controller.sv
// Fetch-side controller: owns the PC and IF/ID register, applies hazard holds
// and EX redirects, requests the ID/EX bubble, and keeps protocol statistics.
module if_stage_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    if_stage_controller_if.slave bus
);

    logic [31:0]      pc_p0;
    logic [31:0]      instr_p1;
    logic [31:0]      pc_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             protocol_err_q;
    logic             misalign_err_q;

    logic             redirect;
    logic             hazard_disagree;
    logic             stall_counted;
    logic             wait_counted;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        redirect        = bus.branch_taken_E;
        hazard_disagree = !redirect &&
                          !((bus.stall == bus.pc_write_zero) &&
                            (bus.pc_write_zero == bus.IFID_pipeline_write_zero));
        stall_counted   = bus.stall && !redirect;
        wait_counted    = !bus.imem_valid && !redirect && !bus.pc_write_zero;
    end

    // Fetch stage: PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= RESET_PC;
        end else if (redirect) begin
            pc_p0 <= {bus.branch_target_E[31:2], 2'b00};
        end else if (!bus.pc_write_zero && bus.imem_valid) begin
            pc_p0 <= pc_p0 + 32'd4;
        end
    end

    // IF/ID boundary: an empty fetch or a redirect leaves a bubble behind
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            instr_p1 <= NOP_INSTR;
            pc_p1    <= 32'd0;
            vld_p1   <= 1'b0;
        end else if (!bus.IFID_pipeline_write_zero) begin
            if (bus.imem_valid) begin
                instr_p1 <= bus.imem_rdata;
                pc_p1    <= pc_p0;
                vld_p1   <= 1'b1;
            end else begin
                instr_p1 <= NOP_INSTR;
                pc_p1    <= 32'd0;
                vld_p1   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            protocol_err_q <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            if (stall_counted) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (redirect)      flush_cnt_q <= sat_inc(flush_cnt_q);
            if (wait_counted)  wait_cnt_q  <= sat_inc(wait_cnt_q);
            if (hazard_disagree) protocol_err_q <= 1'b1;
            if (redirect && (bus.branch_target_E[1:0] != 2'b00)) misalign_err_q <= 1'b1;
        end
    end

    assign bus.imem_addr     = pc_p0;
    assign bus.pc_F          = pc_p0;
    assign bus.instr_D       = instr_p1;
    assign bus.pc_D          = pc_p1;
    assign bus.valid_D       = vld_p1;
    assign bus.idex_flush    = !reset && (bus.stall || redirect);
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
    assign bus.imem_wait_cnt = wait_cnt_q;
    assign bus.protocol_err  = protocol_err_q;
    assign bus.misalign_err  = misalign_err_q;

endmodule

// File: tb/tb_if_stage_controller.sv
// Randomized scoreboard bench for if_stage_controller: a 32-bit-counter and a
// 4-bit-counter instance share stimulus and are checked against one model.
module tb_if_stage_controller;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_i;
    logic st_i, pw_i, iw_i, br_i, iv_i;
    logic [31:0] tg_i;

    always #5 clk = ~clk;

    if_stage_controller_if #(.CNT_W(32)) b32 ();
    if_stage_controller_if #(.CNT_W(4))  b4 ();

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F};
    endfunction

    assign b32.stall = st_i;  assign b4.stall = st_i;
    assign b32.pc_write_zero = pw_i;  assign b4.pc_write_zero = pw_i;
    assign b32.IFID_pipeline_write_zero = iw_i;  assign b4.IFID_pipeline_write_zero = iw_i;
    assign b32.branch_taken_E = br_i;  assign b4.branch_taken_E = br_i;
    assign b32.branch_target_E = tg_i;  assign b4.branch_target_E = tg_i;
    assign b32.imem_valid = iv_i;  assign b4.imem_valid = iv_i;
    assign b32.imem_rdata = iv_i ? mem_f(b32.imem_addr) : 32'hBAD0_0BAD;
    assign b4.imem_rdata  = iv_i ? mem_f(b4.imem_addr)  : 32'hBAD0_0BAD;

    if_stage_controller #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .CNT_W(32)) dut32 (
        .clk(clk), .reset(rst_i), .bus(b32.slave));
    if_stage_controller #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .CNT_W(4)) dut4 (
        .clk(clk), .reset(rst_i), .bus(b4.slave));

    typedef struct {
        logic        flush;
        logic        chk_addr;
        logic [31:0] addr;
        logic [31:0] pc, instr, pcd;
        logic        vld;
        logic [63:0] sc, fc, wc;
        logic        perr, merr;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural state, raw (unsaturated) event counts
    logic [31:0] m_pc, m_instr, m_pcd;
    logic        m_vld, m_perr, m_merr;
    logic        m_init = 1'b0;
    logic [63:0] m_sc, m_fc, m_wc;

    function automatic logic [63:0] sat(input logic [63:0] raw, input int w);
        logic [63:0] cap;
        cap = (64'd1 << w) - 64'd1;
        return (raw > cap) ? cap : raw;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic st, input logic pw, input logic iw,
                         input logic br, input logic [31:0] tg, input logic iv);
        exp_t e;
        logic [31:0] old_pc;
        @(negedge clk);
        rst_i = r; st_i = st; pw_i = pw; iw_i = iw; br_i = br; tg_i = tg; iv_i = iv;
        e.flush    = !r && (st || br);
        e.chk_addr = m_init;
        e.addr     = m_pc;
        old_pc     = m_pc;
        if (r) begin
            m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcd = 0; m_vld = 0;
            m_sc = 0; m_fc = 0; m_wc = 0; m_perr = 0; m_merr = 0; m_init = 1'b1;
        end else begin
            if (br || (!iw && !iv)) begin
                m_instr = NOP_INSTR; m_pcd = 0; m_vld = 0;
            end else if (!iw) begin
                m_instr = mem_f(old_pc); m_pcd = old_pc; m_vld = 1;
            end
            if (br)             m_pc = {tg[31:2], 2'b00};
            else if (!pw && iv) m_pc = old_pc + 32'd4;
            if (st && !br)        m_sc++;
            if (br)               m_fc++;
            if (!iv && !br && !pw) m_wc++;
            if (!br && !(st == pw && pw == iw)) m_perr = 1'b1;
            if (br && tg[1:0] != 2'b00)          m_merr = 1'b1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.vld = m_vld;
        e.sc = m_sc; e.fc = m_fc; e.wc = m_wc; e.perr = m_perr; e.merr = m_merr;
        q.push_back(e);
    endtask

    task automatic norm(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 32'h0, 1);
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q[0];
                chk("idex_flush", 64'(b32.idex_flush), 64'(e.flush));
                chk("idex_flush4", 64'(b4.idex_flush), 64'(e.flush));
                if (e.chk_addr) chk("imem_addr", 64'(b32.imem_addr), 64'(e.addr));
                @(posedge clk);
                #1;
                chk("pc_F", 64'(b32.pc_F), 64'(e.pc));
                chk("instr_D", 64'(b32.instr_D), 64'(e.instr));
                chk("pc_D", 64'(b32.pc_D), 64'(e.pcd));
                chk("valid_D", 64'(b32.valid_D), 64'(e.vld));
                chk("stall_cnt", 64'(b32.stall_cnt), sat(e.sc, 32));
                chk("flush_cnt", 64'(b32.flush_cnt), sat(e.fc, 32));
                chk("imem_wait_cnt", 64'(b32.imem_wait_cnt), sat(e.wc, 32));
                chk("protocol_err", 64'(b32.protocol_err), 64'(e.perr));
                chk("misalign_err", 64'(b32.misalign_err), 64'(e.merr));
                chk("pc_F_w4", 64'(b4.pc_F), 64'(e.pc));
                chk("stall_cnt_w4", 64'(b4.stall_cnt), sat(e.sc, 4));
                chk("flush_cnt_w4", 64'(b4.flush_cnt), sat(e.fc, 4));
                chk("imem_wait_cnt_w4", 64'(b4.imem_wait_cnt), sat(e.wc, 4));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int waitc;
        logic r, st, pw, iw, br, iv, h;
        logic [31:0] tg;
        rst_i = 1; st_i = 0; pw_i = 0; iw_i = 0; br_i = 0; tg_i = 0; iv_i = 0;

        cycle(1, 0, 0, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 0, 0, 32'h0, 1);
        norm(2);                                   // pc 0 -> 4 -> 8
        cycle(0, 1, 1, 1, 0, 32'h0, 1);            // full hazard hold at pc 8
        norm(6);
        cycle(0, 0, 0, 0, 1, 32'h0000_0100, 1);    // redirect
        norm(2);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);            // imem waits
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        norm(1);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 1, 32'h0000_0200, 0);    // branch during a wait
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        norm(1);
        cycle(0, 1, 1, 1, 1, 32'h0000_0300, 1);    // branch beats stall
        cycle(0, 1, 1, 0, 0, 32'h0, 1);            // disagreeing hazard lines
        norm(1);
        cycle(0, 0, 0, 0, 1, 32'h0000_0102, 1);    // misaligned target
        norm(1);
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);    // PC wrap
        norm(2);
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 1, 0, 32'h0, 1);
        cycle(1, 1, 1, 1, 1, 32'h0000_0400, 1);    // reset beats stall and redirect
        norm(2);

        for (int i = 0; i < 600; i++) begin
            h  = ($urandom_range(3) == 0);
            st = h; pw = h; iw = h;
            if ($urandom_range(99) < 5) begin
                st = 1'($urandom_range(1));
                pw = 1'($urandom_range(1));
                iw = 1'($urandom_range(1));
            end
            br = ($urandom_range(9) == 0);
            tg = $urandom;
            if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
            iv = ($urandom_range(4) != 0);
            r  = ($urandom_range(59) == 0);
            cycle(r, st, pw, iw, br, tg, iv);
        end

        waitc = 0;
        while (q.size() > 0 && waitc < 100) begin
            @(posedge clk);
            waitc++;
        end
        n_tests++;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_controller.md
Name: if_stage_controller

Overview:
Fetch-side responder to the load-use hazard detector and the branch resolver. It owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address. It applies the detector's stall, pc_write_zero and IFID_pipeline_write_zero requests, applies branch redirects from EX, and generates the ID/EX bubble. It also keeps saturating performance counters and sticky error flags for hazard-protocol checking.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction inserted into IF/ID on bubble/flush (addi x0,x0,0)
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  load-use stall request from hazard detector
pc_write_zero  input  1  hold PC this cycle
IFID_pipeline_write_zero  input  1  hold IF/ID register this cycle
branch_taken_E  input  1  taken branch/jump resolved in EX
branch_target_E  input  32  redirect target
imem_valid  input  1  imem_rdata valid this cycle for address imem_addr
imem_rdata  input  32  fetched instruction
imem_addr  output  32  fetch address, equal to pc_F
pc_F  output  32  current PC register
instr_D  output  32  IF/ID instruction
pc_D  output  32  IF/ID PC
valid_D  output  1  IF/ID holds a real instruction
idex_flush  output  1  load NOP/zero control into ID/EX this cycle
stall_cnt  output  CNT_W  cycles with a load-use stall applied
flush_cnt  output  CNT_W  taken-branch flushes
imem_wait_cnt  output  CNT_W  cycles lost waiting on imem_valid
protocol_err  output  1  sticky; hazard request lines disagreed
misalign_err  output  1  sticky; branch target bits[1:0] != 0

Behaviour:
- Reset (synchronous, highest priority): pc_F<=RESET_PC; instr_D<=NOP_INSTR; pc_D<=0; valid_D<=0; all counters<=0; protocol_err<=0; misalign_err<=0. While reset=1, idex_flush=0.
- imem_addr = pc_F, combinational. imem_rdata is sampled only when imem_valid=1. The address is held until consumed.
- PC next-state priority:
  - branch_taken_E: pc_F<={branch_target_E[31:2],2'b00}.
  - else pc_write_zero: hold pc_F.
  - else imem_valid=0: hold pc_F.
  - else pc_F<=pc_F+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- IF/ID next-state priority:
  - branch_taken_E: instr_D<=NOP_INSTR, valid_D<=0, pc_D<=0.
  - else IFID_pipeline_write_zero: hold all three.
  - else imem_valid=0: bubble (NOP_INSTR, valid_D=0, pc_D<=0).
  - else instr_D<=imem_rdata, pc_D<=pc_F, valid_D<=1.
- idex_flush = !reset & (stall | branch_taken_E), combinational, same cycle. The registers update on the following edge: 1-cycle latency.
- Redirect penalty: 2 bubbles (IF/ID and ID/EX). The first instruction from the target appears in instr_D 1 cycle after the redirect, provided imem_valid=1.
- Branch and stall in the same cycle: branch wins. stall_cnt is not incremented; flush_cnt is incremented.
- Counters: all saturate at all-ones and never wrap.
  - stall_cnt += 1 when stall & !branch_taken_E.
  - flush_cnt += 1 when branch_taken_E.
  - imem_wait_cnt += 1 when !imem_valid & !branch_taken_E & !pc_write_zero.
- protocol_err: set when !branch_taken_E and stall, pc_write_zero and IFID_pipeline_write_zero are not all equal. Cleared only by reset.
- misalign_err: set when branch_taken_E & (branch_target_E[1:0] != 0). Cleared only by reset.
- Reset in the middle of a stall or redirect: reset wins in that cycle. The next cycle fetches from RESET_PC with no residual stall.

Test Plan:
- Reset then imem_valid=1 with rdata = 0x00500093, 0x00A00113 -> pc_F steps 0,4,8; instr_D=0x00500093 with pc_D=0, then 0x00A00113 with pc_D=4; valid_D=1; counters=0.
- Hold all three hazard lines high for 1 cycle at pc_F=8 -> pc_F and instr_D are held, idex_flush=1 that cycle, stall_cnt=1, protocol_err=0. The next cycle resumes with pc_F=12.
- branch_taken_E=1 with target 0x100 at pc_F=0x20 -> idex_flush=1; next edge gives pc_F=0x100, instr_D=NOP_INSTR, valid_D=0, flush_cnt=1. One cycle later instr_D = rdata fetched at 0x100 with pc_D=0x100.
- imem_valid=0 for 3 cycles -> pc_F is held, IF/ID gets NOP with valid_D=0, imem_wait_cnt=3. With branch_taken_E also asserted in the 2nd of those cycles: redirect taken, imem_wait_cnt=2.
- stall=1 with IFID_pipeline_write_zero=0 -> protocol_err=1 and stays set until reset. Target 0x102 -> pc_F=0x100, misalign_err=1.
- CNT_W=4 with 20 stall cycles -> stall_cnt saturates at 15. Reset asserted during a stall -> pc_F=RESET_PC, all counters 0.
